// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the RV32 subset datapath. It sequences fetch, decode and execute
// through req/ready memory handshakes, counts retired instructions and halts on faults.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruccion,
  input  logic             instr_ready,
  input  logic             data_ready,
  output logic             instr_req,
  output logic             data_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [1:0]       ResultScr,
  output logic             MemWrite,
  output logic [1:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_debug
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMADR = 3'd3,
    MEM    = 3'd4,
    LWB    = 3'd5,
    JUMP   = 3'd6,
    HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_ALU,
    K_LUI,
    K_LW,
    K_SW,
    K_JMP,
    K_ILL
  } kind_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_next;
  kind_t       kind;
  logic [7:0]  wait_cnt;
  logic [1:0]  cause_next;
  logic        dec_alu_src;
  logic [1:0]  dec_alu_ctrl, dec_imm_src, dec_pc_src, dec_result;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        unused_instr;

  assign opcode       = instruccion[6:0];
  assign funct3       = instruccion[14:12];
  assign funct7_b5    = instruccion[30];
  assign unused_instr = ^{instruccion[31], instruccion[29:15], instruccion[11:7]};
  assign state_debug  = state;

  // Decode the IR into an instruction class plus the static datapath controls.
  always_comb begin
    kind         = K_ILL;
    dec_alu_src  = 1'b0;
    dec_alu_ctrl = 2'b00;
    dec_imm_src  = 2'b00;
    dec_pc_src   = 2'b00;
    dec_result   = 2'b00;
    case (opcode)
      7'b0110011: begin
        case (funct3)
          3'b000: begin kind = K_ALU; dec_alu_ctrl = funct7_b5 ? 2'b01 : 2'b00; end
          3'b111: begin kind = K_ALU; dec_alu_ctrl = 2'b10; end
          3'b110: begin kind = K_ALU; dec_alu_ctrl = 2'b11; end
          default: kind = K_ILL;
        endcase
      end
      7'b0010011: begin
        case (funct3)
          3'b000: begin kind = K_ALU; dec_alu_src = 1'b1; dec_alu_ctrl = 2'b00; end
          3'b111: begin kind = K_ALU; dec_alu_src = 1'b1; dec_alu_ctrl = 2'b10; end
          3'b110: begin kind = K_ALU; dec_alu_src = 1'b1; dec_alu_ctrl = 2'b11; end
          default: kind = K_ILL;
        endcase
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          kind        = K_LW;
          dec_alu_src = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          kind        = K_SW;
          dec_alu_src = 1'b1;
          dec_imm_src = 2'b01;
        end
      end
      7'b0110111: begin
        kind        = K_LUI;
        dec_imm_src = 2'b10;
        dec_result  = 2'b10;
      end
      7'b1101111: begin
        kind        = K_JMP;
        dec_imm_src = 2'b11;
        dec_pc_src  = 2'b01;
        dec_result  = 2'b11;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          kind        = K_JMP;
          dec_alu_src = 1'b1;
          dec_pc_src  = 2'b10;
          dec_result  = 2'b11;
        end
      end
      default: kind = K_ILL;
    endcase
  end

  // Next-state and output logic; strobes are masked while reset is held.
  always_comb begin
    state_next = state;
    cause_next = 2'b00;
    instr_req  = 1'b0;
    data_req   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    PCSrc      = 2'b00;
    ALUSrc     = 1'b0;
    ResultScr  = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = 2'b00;

    if (state != FETCH && state != HALT) begin
      PCSrc      = dec_pc_src;
      ALUSrc     = dec_alu_src;
      ResultScr  = dec_result;
      ALUControl = dec_alu_ctrl;
      ImmSrc     = dec_imm_src;
    end

    case (state)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          IRWrite    = 1'b1;
          state_next = DECODE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state_next = HALT;
          cause_next = 2'b10;
        end
      end
      DECODE: begin
        case (kind)
          K_ALU, K_LUI: state_next = EXEC;
          K_LW, K_SW:   state_next = MEMADR;
          K_JMP:        state_next = JUMP;
          default: begin
            state_next = HALT;
            cause_next = 2'b01;
          end
        endcase
      end
      EXEC: begin
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        state_next = FETCH;
      end
      MEMADR: state_next = MEM;
      MEM: begin
        data_req = 1'b1;
        MemWrite = (kind == K_SW);
        if (data_ready) begin
          if (kind == K_SW) begin
            PCWrite    = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = LWB;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state_next = HALT;
          cause_next = 2'b11;
        end
      end
      LWB: begin
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        ResultScr  = 2'b01;
        state_next = FETCH;
      end
      JUMP: begin
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        state_next = FETCH;
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase

    if (reset) begin
      instr_req = 1'b0;
      data_req  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
    end
  end

  // The wait counter restarts on every state change, so it only ever counts idle FETCH/MEM cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      wait_cnt   <= 8'd0;
      retired    <= '0;
      halt       <= 1'b0;
      halt_cause <= 2'b00;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= 8'd0;
      end else if (state == FETCH || state == MEM) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (PCWrite) begin
        retired <= retired + CNT_W'(1);
      end
      if (state_next == HALT && state != HALT) begin
        halt       <= 1'b1;
        halt_cause <= cause_next;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle schedule
// (state, strobes, controls) from its instruction class and memory wait pattern.
module tb_multicycle_control_fsm;

  localparam int T = 16;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEMADR = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_LWB    = 3'd5;
  localparam logic [2:0] S_JUMP   = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_ADDI = 4, K_ANDI = 5, K_ORI = 6;
  localparam int K_LW = 7, K_SW = 8, K_LUI = 9, K_JAL = 10, K_JALR = 11, K_ILL = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruccion = 32'd0;
  logic        instr_ready = 1'b0;
  logic        data_ready = 1'b0;
  logic        instr_req, data_req, IRWrite, PCWrite, ALUSrc, RegWrite, MemWrite, halt;
  logic [1:0]  PCSrc, ResultScr, ALUControl, ImmSrc, halt_cause;
  logic [31:0] retired;
  logic [2:0]  state_debug;

  typedef struct {
    logic [31:0] ir;
    logic [2:0]  st;
    logic        ireq, dreq, irw, pcw, rw, mw;
    logic [1:0]  pcsrc, rsrc, aluctl, immsrc;
    logic        alusrc;
    logic        hlt;
    logic [1:0]  cause;
    logic        irdy, drdy;
  } cyc_t;

  cyc_t        plan[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle_no = 0;
  logic [31:0] exp_retired = 32'd0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instruccion(instruccion),
    .instr_ready(instr_ready), .data_ready(data_ready),
    .instr_req(instr_req), .data_req(data_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ResultScr(ResultScr),
    .MemWrite(MemWrite), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .halt(halt), .halt_cause(halt_cause), .retired(retired), .state_debug(state_debug)
  );

  function automatic void kind_fields(input int k, output logic alusrc, output logic [1:0] aluctl,
                                      output logic [1:0] immsrc, output logic [1:0] pcsrc,
                                      output logic [1:0] rsrc);
    alusrc = 1'b0; aluctl = 2'b00; immsrc = 2'b00; pcsrc = 2'b00; rsrc = 2'b00;
    case (k)
      K_SUB:  aluctl = 2'b01;
      K_AND:  aluctl = 2'b10;
      K_OR:   aluctl = 2'b11;
      K_ADDI: alusrc = 1'b1;
      K_ANDI: begin alusrc = 1'b1; aluctl = 2'b10; end
      K_ORI:  begin alusrc = 1'b1; aluctl = 2'b11; end
      K_LW:   alusrc = 1'b1;
      K_SW:   begin alusrc = 1'b1; immsrc = 2'b01; end
      K_LUI:  begin immsrc = 2'b10; rsrc = 2'b10; end
      K_JAL:  begin immsrc = 2'b11; pcsrc = 2'b01; rsrc = 2'b11; end
      K_JALR: begin alusrc = 1'b1; pcsrc = 2'b10; rsrc = 2'b11; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr(input int k);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [19:0] imm20;
    logic [24:0] junk;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    imm = 12'($urandom); imm20 = 20'($urandom); junk = 25'($urandom);
    case (k)
      K_ADD:  return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_SUB:  return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_AND:  return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      K_OR:   return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      K_ADDI: return {imm, rs1, 3'b000, rd, 7'b0010011};
      K_ANDI: return {imm, rs1, 3'b111, rd, 7'b0010011};
      K_ORI:  return {imm, rs1, 3'b110, rd, 7'b0010011};
      K_LW:   return {imm, rs1, 3'b010, rd, 7'b0000011};
      K_SW:   return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      K_LUI:  return {imm20, rd, 7'b0110111};
      K_JAL:  return {imm20, rd, 7'b1101111};
      K_JALR: return {imm, rs1, 3'b000, rd, 7'b1100111};
      default: begin
        case ($urandom_range(0, 5))
          0: return {junk, 7'b1111111};
          1: return {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
          2: return {imm, rs1, 3'b100, rd, 7'b0010011};
          3: return {imm, rs1, 3'b000, rd, 7'b0000011};
          4: return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0100011};
          default: return {imm, rs1, 3'b001, rd, 7'b1100111};
        endcase
      end
    endcase
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input logic [31:0] ir, input int k, input bit fields);
    cyc_t r;
    r = '{default: '0};
    r.st = st;
    r.ir = ir;
    r.irdy = 1'($urandom);
    r.drdy = 1'($urandom);
    if (fields) kind_fields(k, r.alusrc, r.aluctl, r.immsrc, r.pcsrc, r.rsrc);
    return r;
  endfunction

  task automatic push_halt(input logic [31:0] ir, input logic [1:0] cause);
    cyc_t r;
    for (int i = 0; i < 3; i++) begin
      r = mk(S_HALT, ir, K_ILL, 0);
      r.hlt = 1'b1;
      r.cause = cause;
      plan.push_back(r);
    end
  endtask

  // Expected schedule for one instruction: wf/wd are the idle cycles before each ready.
  task automatic add_instr(input logic [31:0] ir, input int k, input int wf, input int wd, output bit halted);
    cyc_t r;
    halted = 1'b0;
    for (int c = 0; c < T; c++) begin
      r = mk(S_FETCH, ir, k, 0);
      r.ireq = 1'b1;
      if (c == wf) begin
        r.irdy = 1'b1; r.irw = 1'b1;
        plan.push_back(r);
        break;
      end
      r.irdy = 1'b0;
      plan.push_back(r);
      if (c == T - 1) begin push_halt(ir, 2'b10); halted = 1'b1; return; end
    end
    plan.push_back(mk(S_DECODE, ir, k, 1));
    if (k == K_ILL) begin push_halt(ir, 2'b01); halted = 1'b1; return; end
    if (k == K_LW || k == K_SW) begin
      plan.push_back(mk(S_MEMADR, ir, k, 1));
      for (int c = 0; c < T; c++) begin
        r = mk(S_MEM, ir, k, 1);
        r.dreq = 1'b1;
        r.mw = (k == K_SW);
        if (c == wd) begin
          r.drdy = 1'b1; r.pcw = (k == K_SW);
          plan.push_back(r);
          break;
        end
        r.drdy = 1'b0;
        plan.push_back(r);
        if (c == T - 1) begin push_halt(ir, 2'b11); halted = 1'b1; return; end
      end
      if (k == K_LW) begin
        r = mk(S_LWB, ir, k, 1);
        r.rw = 1'b1; r.pcw = 1'b1; r.rsrc = 2'b01;
        plan.push_back(r);
      end
    end else if (k == K_JAL || k == K_JALR) begin
      r = mk(S_JUMP, ir, k, 1);
      r.rw = 1'b1; r.pcw = 1'b1;
      plan.push_back(r);
    end else begin
      r = mk(S_EXEC, ir, k, 1);
      r.rw = 1'b1; r.pcw = 1'b1;
      plan.push_back(r);
    end
  endtask

  task automatic check_output(input cyc_t r);
    logic [17:0] exp_c, obs_c;
    logic [34:0] exp_r, obs_r;
    exp_c = {r.st, r.ireq, r.dreq, r.irw, r.pcw, r.rw, r.mw, r.pcsrc, r.rsrc, r.alusrc, r.aluctl, r.immsrc};
    obs_c = {state_debug, instr_req, data_req, IRWrite, PCWrite, RegWrite, MemWrite,
             PCSrc, ResultScr, ALUSrc, ALUControl, ImmSrc};
    exp_r = {r.hlt, r.cause, exp_retired};
    obs_r = {halt, halt_cause, retired};
    checks++;
    assert (obs_c === exp_c) else begin
      failures++;
      $error("[TB] FAIL comb cyc=%0d ir=%h observed=%h expected=%h", cycle_no, r.ir, obs_c, exp_c);
    end
    checks++;
    assert (obs_r === exp_r) else begin
      failures++;
      $error("[TB] FAIL regs cyc=%0d observed=%h expected=%h", cycle_no, obs_r, exp_r);
    end
  endtask

  task automatic apply_stimulus(input cyc_t r);
    @(negedge clk);
    cycle_no++;
    reset = 1'b0;
    instruccion = r.ir;
    instr_ready = r.irdy;
    data_ready = r.drdy;
    #1;
    check_output(r);
    if (r.pcw) exp_retired++;
  endtask

  // mem_limit > 0 abandons the schedule after that many MEM cycles (used for reset mid-access).
  task automatic run_plan(input int mem_limit);
    cyc_t r;
    int mem_seen;
    mem_seen = 0;
    while (plan.size() > 0) begin
      r = plan.pop_front();
      apply_stimulus(r);
      if (r.st == S_MEM) mem_seen++;
      if (mem_limit > 0 && mem_seen >= mem_limit) plan.delete();
    end
  endtask

  task automatic apply_reset();
    logic [5:0] strobes;
    @(negedge clk);
    cycle_no++;
    reset = 1'b1;
    instr_ready = 1'($urandom);
    data_ready = 1'($urandom);
    #1;
    strobes = {instr_req, data_req, IRWrite, PCWrite, RegWrite, MemWrite};
    checks++;
    assert (strobes === 6'b0) else begin
      failures++;
      $error("[TB] FAIL reset_strobes cyc=%0d observed=%b expected=%b", cycle_no, strobes, 6'b0);
    end
    @(posedge clk);
    exp_retired = 32'd0;
  endtask

  task automatic do_instr(input logic [31:0] ir, input int k, input int wf, input int wd);
    bit h;
    add_instr(ir, k, wf, wd, h);
    run_plan(0);
    if (h) apply_reset();
  endtask

  initial begin
    int k;
    int wf, wd;
    apply_reset();

    $display("[TB] directed sequence");
    do_instr(32'h00500093, K_ADDI, 0, 0);
    do_instr(32'h402081B3, K_SUB, 0, 0);
    do_instr(32'h0020F1B3, K_AND, 1, 0);
    do_instr(32'h00002203, K_LW, 0, 3);
    do_instr(32'h00102023, K_SW, 0, 0);
    do_instr(32'h0080036F, K_JAL, 0, 0);
    do_instr(32'h004103E7, K_JALR, 2, 0);
    do_instr(gen_instr(K_LUI), K_LUI, 0, 0);
    do_instr(gen_instr(K_LW), K_LW, T - 1, T - 1);
    do_instr(32'h0000007F, K_ILL, 0, 0);
    do_instr(32'h00002203, K_LW, 0, 1000);
    do_instr(gen_instr(K_ADD), K_ADD, 1000, 0);

    $display("[TB] reset during MEM");
    do_instr(32'h00500093, K_ADDI, 0, 0);
    begin
      bit h;
      add_instr(32'h00002203, K_LW, 0, 10, h);
      run_plan(2);
    end
    apply_reset();
    do_instr(gen_instr(K_OR), K_OR, 0, 0);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 12);
      if (k == K_ILL && ($urandom % 3) != 0) k = $urandom_range(0, 11);
      wf = ($urandom % 16 == 0) ? 20 : $urandom_range(0, 3);
      wd = ($urandom % 16 == 0) ? 20 : $urandom_range(0, 3);
      do_instr(gen_instr(k), k, wf, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
